window_fetch: RTL and testbench

Window-gather stage directly downstream of the anchor/address generator in the CNN datapath. It accepts one window anchor address per handshake and issues the 25 tap reads for a 5×5 window to the single-port feature-map RAM, one read per cycle. It assembles the returned pixels into one packed window word and hands it to the convolution PE array over a valid/ready interface. It also tracks the window index within the frame and flags the last window.

---
 rtl/cnn_fetch_pkg.sv | 48 ++++
 rtl/window_fetch_if.sv | 42 ++++
 rtl/window_tap_counter.sv | 61 ++++++
 rtl/window_fetch.sv | 166 ++++++++++++++++
 tb/tb_window_fetch.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_fetch_pkg.sv
// -----------------------------------------------------------------------------
// cnn_fetch_pkg
//   Shared types and constants for the CNN window-gather stage.
//   - fetch_state_t : window_fetch FSM encoding.
//   - DEF_*         : default window/image/bus geometry.
//   - TAPS, WIN_PER_FRAME, IMG_SIZE : constants derived from the defaults.
//   - calc_* / width_of : helpers so parameterised modules derive the same
//                         quantities from their own parameter values.
// -----------------------------------------------------------------------------
package cnn_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_OUT
    } fetch_state_t;

    localparam int DEF_WIN_W  = 5;
    localparam int DEF_WIN_H  = 5;
    localparam int DEF_IMG_W  = 30;
    localparam int DEF_IMG_H  = 30;
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 16;

    function automatic int calc_taps(input int win_w, input int win_h);
        return win_w * win_h;
    endfunction

    function automatic int calc_win_per_frame(input int img_w, input int img_h,
                                              input int win_w, input int win_h);
        return (img_w - win_w + 1) * (img_h - win_h + 1);
    endfunction

    function automatic int calc_img_size(input int img_w, input int img_h);
        return img_w * img_h;
    endfunction

    // Bits needed to hold values 0..n-1 (never less than one bit).
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int TAPS          = calc_taps(DEF_WIN_W, DEF_WIN_H);
    localparam int WIN_PER_FRAME = calc_win_per_frame(DEF_IMG_W, DEF_IMG_H, DEF_WIN_W, DEF_WIN_H);
    localparam int IMG_SIZE      = calc_img_size(DEF_IMG_W, DEF_IMG_H);

endpackage

// File: rtl/window_fetch_if.sv
// -----------------------------------------------------------------------------
// window_fetch_if
//   Bundles the three channels of the window-gather stage:
//   - anchor : anchor_valid / anchor_ready / anchor_addr  (from address generator)
//   - memory : mem_rd_en / mem_rd_addr / mem_rd_data       (feature-map RAM, 1-cycle read)
//   - window : win_valid / win_ready / win_data / win_last (to PE array)
//   modport slave  : the window_fetch block itself.
//   modport master : its environment (address generator, RAM and PE array).
// -----------------------------------------------------------------------------
interface window_fetch_if
    import cnn_fetch_pkg::*;
#(
    parameter int WIN_W  = DEF_WIN_W,
    parameter int WIN_H  = DEF_WIN_H,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic                            anchor_valid;
    logic                            anchor_ready;
    logic [ADDR_W-1:0]               anchor_addr;

    logic                            mem_rd_en;
    logic [ADDR_W-1:0]               mem_rd_addr;
    logic [DATA_W-1:0]               mem_rd_data;

    logic                            win_valid;
    logic                            win_ready;
    logic [WIN_W*WIN_H*DATA_W-1:0]   win_data;
    logic                            win_last;

    modport slave (
        input  anchor_valid, anchor_addr, mem_rd_data, win_ready,
        output anchor_ready, mem_rd_en, mem_rd_addr, win_valid, win_data, win_last
    );

    modport master (
        output anchor_valid, anchor_addr, mem_rd_data, win_ready,
        input  anchor_ready, mem_rd_en, mem_rd_addr, win_valid, win_data, win_last
    );

endinterface

// File: rtl/window_tap_counter.sv
// -----------------------------------------------------------------------------
// window_tap_counter
//   Raster counter over the taps of one window, h fastest.
//   Ports:
//   - clk, rst_n : clock, asynchronous active-low reset
//   - clear      : restart at tap (0,0); has priority over step
//   - step       : advance one tap; holds once the last tap is reached
//   - h, v       : current column / row inside the window
//   - row_off    : v*IMG_W, built by repeated addition of IMG_W
//   - last       : current tap is the final one of the window
// -----------------------------------------------------------------------------
module window_tap_counter
    import cnn_fetch_pkg::*;
#(
    parameter int WIN_W = DEF_WIN_W,
    parameter int WIN_H = DEF_WIN_H,
    parameter int IMG_W = DEF_IMG_W,
    parameter int OFF_W = DEF_ADDR_W + 1,
    localparam int H_W  = width_of(WIN_W),
    localparam int V_W  = width_of(WIN_H)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             step,
    output logic [H_W-1:0]   h,
    output logic [V_W-1:0]   v,
    output logic [OFF_W-1:0] row_off,
    output logic             last
);

    logic h_end;

    always_comb begin
        h_end = (h == H_W'(WIN_W - 1));
        last  = h_end && (v == V_W'(WIN_H - 1));
    end

    // NOTE: registers are written with <= so every flop in this block samples
    // the pre-edge values of its neighbours; = here would chain h into v.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h       <= '0;
            v       <= '0;
            row_off <= '0;
        end else if (clear) begin
            h       <= '0;
            v       <= '0;
            row_off <= '0;
        end else if (step && !last) begin
            if (h_end) begin
                h       <= '0;
                v       <= v + 1'b1;
                row_off <= row_off + OFF_W'(IMG_W);
            end else begin
                h <= h + 1'b1;
            end
        end
    end

endmodule

// File: rtl/window_fetch.sv
// -----------------------------------------------------------------------------
// window_fetch
//   Accepts one window anchor, reads the WIN_W x WIN_H taps from the
//   single-port feature-map RAM one per cycle, packs them into one window word
//   and offers it to the PE array. Tracks the window index within the frame
//   and flags the last window.
//   Ports:
//   - clk, rst_n : clock, asynchronous active-low reset
//   - bus        : window_fetch_if.slave (anchor, memory and window channels)
//   Taps whose linear address falls past the image are not read and pack as 0.
// -----------------------------------------------------------------------------
module window_fetch
    import cnn_fetch_pkg::*;
#(
    parameter int WIN_W  = DEF_WIN_W,
    parameter int WIN_H  = DEF_WIN_H,
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input logic           clk,
    input logic           rst_n,
    window_fetch_if.slave bus
);

    localparam int N_TAPS   = calc_taps(WIN_W, WIN_H);
    localparam int N_WIN    = calc_win_per_frame(IMG_W, IMG_H, WIN_W, WIN_H);
    localparam int N_PIX    = calc_img_size(IMG_W, IMG_H);
    localparam int H_W      = width_of(WIN_W);
    localparam int V_W      = width_of(WIN_H);
    localparam int K_W      = width_of(N_TAPS);
    localparam int IDX_W    = width_of(N_WIN);
    localparam int EXT_W    = ADDR_W + 1;
    localparam int WIN_BITS = N_TAPS * DATA_W;

    fetch_state_t        state;
    logic [ADDR_W-1:0]   anchor_q;
    logic                anchor_ready_q;
    logic                win_valid_q;
    logic                win_last_q;
    logic [IDX_W-1:0]    win_idx;
    logic [WIN_BITS-1:0] win_data_q;

    logic                accept;
    logic                fetching;
    logic [H_W-1:0]      tap_h;
    logic [V_W-1:0]      tap_v;
    logic [EXT_W-1:0]    row_off;
    logic                tap_last;
    logic [EXT_W-1:0]    tap_addr;
    logic                tap_oor;
    logic [K_W-1:0]      tap_k;

    // Read-return pipeline: tap slot and out-of-range flag ride alongside the
    // RAM's one-cycle read latency.
    logic                cap_valid;
    logic                cap_oor;
    logic [K_W-1:0]      cap_k;

    // anchor_ready_q is only ever high in IDLE, so this is the IDLE handshake.
    assign accept = bus.anchor_valid && anchor_ready_q;

    window_tap_counter #(
        .WIN_W (WIN_W),
        .WIN_H (WIN_H),
        .IMG_W (IMG_W),
        .OFF_W (EXT_W)
    ) u_tap_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (accept),
        .step    (fetching),
        .h       (tap_h),
        .v       (tap_v),
        .row_off (row_off),
        .last    (tap_last)
    );

    // NOTE: every signal of this block is assigned on every pass, with no
    // if/case leaving one untouched, so no latch can be inferred.
    always_comb begin
        fetching = (state == ST_FETCH);
        // One extra bit so an anchor near the top of the address space cannot
        // wrap back into the image.
        tap_addr = {1'b0, anchor_q} + EXT_W'(tap_h) + row_off;
        tap_oor  = (tap_addr >= EXT_W'(N_PIX));
        tap_k    = K_W'(tap_v) * K_W'(WIN_W) + K_W'(tap_h);
    end

    // The read strobe follows the registered FSM/counter state directly so the
    // first tap is issued in the cycle right after acceptance. The address is
    // parked at 0 whenever no read is issued.
    assign bus.mem_rd_en   = fetching && !tap_oor;
    assign bus.mem_rd_addr = (fetching && !tap_oor) ? tap_addr[ADDR_W-1:0] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            anchor_q       <= '0;
            anchor_ready_q <= 1'b0;
            win_valid_q    <= 1'b0;
            win_last_q     <= 1'b0;
            win_idx        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    anchor_ready_q <= 1'b1;
                    if (accept) begin
                        anchor_q       <= bus.anchor_addr;
                        anchor_ready_q <= 1'b0;
                        state          <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (tap_last) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Last tap lands this edge in the capture block.
                    win_valid_q <= 1'b1;
                    win_last_q  <= (win_idx == IDX_W'(N_WIN - 1));
                    state       <= ST_OUT;
                end
                ST_OUT: begin
                    if (bus.win_ready) begin
                        win_valid_q    <= 1'b0;
                        win_last_q     <= 1'b0;
                        win_idx        <= (win_idx == IDX_W'(N_WIN - 1)) ? '0 : win_idx + 1'b1;
                        // Ready for the next anchor in the very next (IDLE) cycle.
                        anchor_ready_q <= 1'b1;
                        state          <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // NOTE: the window register bank is a plain flop array, not a RAM macro,
    // so it takes the async reset and presents an all-zero window out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_valid  <= 1'b0;
            cap_oor    <= 1'b0;
            cap_k      <= '0;
            win_data_q <= '0;
        end else begin
            cap_valid <= fetching;
            cap_oor   <= tap_oor;
            cap_k     <= tap_k;
            if (cap_valid) begin
                win_data_q[cap_k*DATA_W +: DATA_W] <= cap_oor ? '0 : bus.mem_rd_data;
            end
        end
    end

    assign bus.anchor_ready = anchor_ready_q;
    assign bus.win_valid    = win_valid_q;
    assign bus.win_last     = win_last_q;
    assign bus.win_data     = win_data_q;

endmodule

// File: tb/tb_window_fetch.sv
// -----------------------------------------------------------------------------
// tb_window_fetch
//   Self-checking bench for window_fetch: RAM model, randomized anchors and
//   RAM contents, and a reference model that computes each window, its read
//   sequence and the frame index from the geometry rules directly.
// -----------------------------------------------------------------------------
module tb_window_fetch;

    localparam int WIN_W  = 5;
    localparam int WIN_H  = 5;
    localparam int IMG_W  = 30;
    localparam int IMG_H  = 30;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;
    localparam int NTAP   = WIN_W * WIN_H;
    localparam int CW     = NTAP * DATA_W;
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int LAST   = (IMG_W - WIN_W + 1) * (IMG_H - WIN_H + 1) - 1;

    logic clk;
    logic rst_n;

    window_fetch_if #(
        .WIN_W (WIN_W), .WIN_H (WIN_H), .ADDR_W (ADDR_W), .DATA_W (DATA_W)
    ) bus ();

    window_fetch #(
        .WIN_W (WIN_W), .WIN_H (WIN_H), .IMG_W (IMG_W), .IMG_H (IMG_H),
        .ADDR_W (ADDR_W), .DATA_W (DATA_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int idx    = 0;                 // model of the frame window index
    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
    logic [CW-1:0]     last_win;
    int rd_cyc  [$];
    int rd_addr [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Feature-map RAM: data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (bus.mem_rd_en === 1'b1) bus.mem_rd_data <= ram[bus.mem_rd_addr];
    end

    // Read monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.mem_rd_en === 1'b1) begin
            rd_cyc.push_back(cyc);
            rd_addr.push_back(int'(bus.mem_rd_addr));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_anchor_ready"}, bus.anchor_ready, 1'b0);
        check({pfx, "_mem_rd_en"},    bus.mem_rd_en,    1'b0);
        check({pfx, "_mem_rd_addr"},  bus.mem_rd_addr,  '0);
        check({pfx, "_win_valid"},    bus.win_valid,    1'b0);
        check({pfx, "_win_data"},     bus.win_data,     '0);
        check({pfx, "_win_last"},     bus.win_last,     1'b0);
    endtask

    // Entered and left on a negedge. stall>0 holds win_ready low that many
    // cycles after win_valid; rst_at>0 resets the block at that cycle of the fetch.
    task automatic run_window(input int a, input int stall, input int rst_at);
        logic [CW-1:0] exp_win;
        logic [CW-1:0] snap;
        int exp_addr [$];
        int exp_rel  [$];
        int n, t_acc, nbad;

        exp_win = '0;
        for (int k = 0; k < NTAP; k++) begin
            int ta;
            ta = a + (k % WIN_W) + (k / WIN_W) * IMG_W;
            if (ta < NPIX) begin
                exp_win[k*DATA_W +: DATA_W] = ram[ta];
                exp_addr.push_back(ta);
                exp_rel.push_back(k + 1);
            end
        end

        bus.win_ready = (stall == 0);
        n = 0;
        while (bus.anchor_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("anchor_ready_wait", bus.anchor_ready, 1'b1);
        rd_cyc.delete();
        rd_addr.delete();
        bus.anchor_valid = 1'b1;
        bus.anchor_addr  = ADDR_W'(a);
        @(posedge clk);
        @(negedge clk);
        bus.anchor_valid = 1'b0;
        t_acc = cyc;
        n = 1;

        if (rst_at > 0) begin
            while (n < rst_at) begin
                @(negedge clk);
                n++;
            end
            rst_n = 1'b0;
            #1;
            check_reset_outputs("midrst");
            repeat (3) @(posedge clk);
            @(negedge clk);
            check_reset_outputs("midrst_hold");
            rst_n = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check("midrst_idle_ready", bus.anchor_ready, 1'b1);
            idx = 0;
            return;
        end

        while (bus.win_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, 27);
        check("win_data", bus.win_data, exp_win);
        check("win_last", bus.win_last, (idx == LAST));
        last_win = bus.win_data;
        snap     = bus.win_data;

        if (stall > 0) begin
            nbad = 0;
            for (int c = 0; c < stall; c++) begin
                bus.anchor_valid = 1'($urandom_range(0, 1));
                bus.anchor_addr  = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
                @(negedge clk);
                if (bus.win_data !== snap || bus.win_valid !== 1'b1 ||
                    bus.mem_rd_en !== 1'b0 || bus.anchor_ready !== 1'b0) nbad++;
            end
            check("stall_hold_bad_cycles", nbad, 0);
            bus.anchor_valid = 1'b0;
            bus.win_ready    = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end else begin
            @(negedge clk);
        end
        check("valid_drop", bus.win_valid, 1'b0);
        check("idle_ready", bus.anchor_ready, 1'b1);

        nbad = 0;
        if (rd_addr.size() != exp_addr.size()) begin
            nbad = 1000 + rd_addr.size();
        end else begin
            for (int i = 0; i < exp_addr.size(); i++) begin
                if (rd_addr[i] != exp_addr[i] || rd_cyc[i] - t_acc + 1 != exp_rel[i]) nbad++;
            end
        end
        check("rd_seq_bad", nbad, 0);
        idx = (idx == LAST) ? 0 : idx + 1;
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.anchor_valid = 1'b0;
        bus.anchor_addr  = '0;
        bus.win_ready    = 1'b0;
        bus.mem_rd_data  = '0;
        last_win         = '0;
        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = DATA_W'(i);

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ready_after_reset", bus.anchor_ready, 1'b1);

        // RAM[a] = a, anchor 0.
        run_window(0, 0, 0);
        check("tap24_anchor0", last_win[24*DATA_W +: DATA_W], DATA_W'(124));

        // RAM[a] = a+1, anchor 880: bottom rows fall off the image.
        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = DATA_W'(i + 1);
        run_window(880, 0, 0);
        check("tap0_anchor880", last_win[0 +: DATA_W], DATA_W'(881));
        check("tap24_anchor880_oor", last_win[24*DATA_W +: DATA_W], '0);

        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = DATA_W'($urandom);
        run_window($urandom_range(0, (1 << ADDR_W) - 1), 40, 0);

        // Walk up to the final window index, then reset in the middle of it.
        while (idx != LAST) run_window($urandom_range(0, (1 << ADDR_W) - 1), 0, 0);
        run_window($urandom_range(0, NPIX - 1), 0, 12);

        // Full frame from index 0: last only on window 676, then wrap.
        for (int w = 0; w <= LAST + 1; w++) begin
            run_window($urandom_range(0, (1 << ADDR_W) - 1), 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
